// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: accepts a word over valid/ready, gates the external
// baud counter for one frame and steps start/data/stop bits on each baud tick.
module uart_tx_sequencer #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 baud_en,
    input  logic                 baud_tick,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_n;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     bit_idx_n;
    logic                 stop_idx;
    logic                 stop_idx_n;
    logic                 txd_n;
    logic                 baud_en_n;
    logic                 busy_n;
    logic                 tx_done_n;
    logic                 accept;
    logic                 last_bit;
    logic                 last_stop;

    assign tx_ready  = (state == IDLE) & ~rst;
    assign accept    = tx_valid & tx_ready;
    assign last_bit  = (bit_idx == IDX_W'(DATA_BITS - 1));
    assign last_stop = (stop_idx == 1'(STOP_BITS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and datapath next values; baud_tick only matters outside IDLE
    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        case (state)
            IDLE: begin
                if (accept) begin
                    shift_n = tx_data;
                    state_n = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    bit_idx_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (last_bit) begin
                        stop_idx_n = 1'b0;
                        state_n    = STOP;
                    end else begin
                        shift_n   = shift >> 1;
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (last_stop) begin
                        state_n = IDLE;
                    end else begin
                        stop_idx_n = stop_idx + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered pins track it
    always_comb begin
        txd_n     = 1'b1;
        baud_en_n = 1'b0;
        busy_n    = 1'b0;
        tx_done_n = 1'b0;
        case (state_n)
            IDLE: begin
                tx_done_n = (state == STOP);
            end
            START: begin
                txd_n     = 1'b0;
                baud_en_n = 1'b1;
                busy_n    = 1'b1;
            end
            DATA: begin
                txd_n     = shift_n[0];
                baud_en_n = 1'b1;
                busy_n    = 1'b1;
            end
            STOP: begin
                baud_en_n = 1'b1;
                busy_n    = 1'b1;
            end
            default: begin
                txd_n = 1'b1;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            shift    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            txd      <= 1'b1;
            baud_en  <= 1'b0;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            shift    <= shift_n;
            bit_idx  <= bit_idx_n;
            stop_idx <= stop_idx_n;
            txd      <= txd_n;
            baud_en  <= baud_en_n;
            busy     <= busy_n;
            tx_done  <= tx_done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: two instances (8N1 with P=4, 7-bit/2-stop with P=8)
// each driven by a behavioural baud counter; frames checked against a scoreboard.
module tb_uart_tx_sequencer;

    localparam int unsigned PA = 4;
    localparam int unsigned PB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic [7:0] tx_data_a  = '0;
    logic       tx_valid_a = 1'b0;
    logic       tx_ready_a, baud_en_a, tick_a, txd_a, busy_a, done_a;
    logic       inj_a      = 1'b0;
    logic [3:0] cnt_a      = '0;

    logic [6:0] tx_data_b  = '0;
    logic       tx_valid_b = 1'b0;
    logic       tx_ready_b, baud_en_b, tick_b, txd_b, busy_b, done_b;
    logic       inj_b      = 1'b0;
    logic [3:0] cnt_b      = '0;

    uart_tx_sequencer #(.DATA_BITS(8), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .baud_en(baud_en_a), .baud_tick(tick_a),
        .txd(txd_a), .busy(busy_a), .tx_done(done_a)
    );

    uart_tx_sequencer #(.DATA_BITS(7), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .baud_en(baud_en_b), .baud_tick(tick_b),
        .txd(txd_b), .busy(busy_b), .tx_done(done_b)
    );

    // Baud counter models: cleared while disabled, first tick P cycles after enable
    always @(posedge clk) begin
        if (!baud_en_a || cnt_a == 4'(PA - 1)) cnt_a <= '0;
        else cnt_a <= cnt_a + 4'd1;
        if (!baud_en_b || cnt_b == 4'(PB - 1)) cnt_b <= '0;
        else cnt_b <= cnt_b + 4'd1;
    end
    assign tick_a = (baud_en_a && cnt_a == 4'(PA - 1)) || inj_a;
    assign tick_b = (baud_en_b && cnt_b == 4'(PB - 1)) || inj_b;

    // Scoreboard: expected frame pushed on every accept edge
    logic [15:0] exp_a = '0;
    logic [15:0] exp_b = '0;
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    always @(posedge clk) begin
        if (!rst && tx_valid_a && tx_ready_a) q_a.push_back(exp_a);
        if (!rst && tx_valid_b && tx_ready_b) q_b.push_back(exp_b);
    end

    bit   sel = 1'b0;
    logic mon_txd, mon_en, mon_busy, mon_done, mon_ready;
    assign mon_txd   = sel ? txd_b      : txd_a;
    assign mon_en    = sel ? baud_en_b  : baud_en_a;
    assign mon_busy  = sel ? busy_b     : busy_a;
    assign mon_done  = sel ? done_b     : done_a;
    assign mon_ready = sel ? tx_ready_b : tx_ready_a;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Follows one frame from the current negedge; leaves off in the first IDLE cycle
    task automatic check_frame(input int nbits, input int p);
        int          waited = 0;
        logic [15:0] exp;
        logic        ok;
        while (!(mon_txd === 1'b0 && mon_busy === 1'b1) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            chk("start_timeout", 16'(mon_txd), 16'd0);
            return;
        end
        chk("sb_depth", 16'(sel ? q_b.size() : q_a.size()), 16'd1);
        exp = '0;
        if (sel && q_b.size() > 0) exp = q_b.pop_front();
        else if (!sel && q_a.size() > 0) exp = q_a.pop_front();
        for (int i = 0; i < nbits; i++) begin
            ok = 1'b1;
            for (int c = 0; c < p; c++) begin
                if (mon_txd !== exp[i] || mon_busy !== 1'b1 || mon_en !== 1'b1 || mon_done !== 1'b0)
                    ok = 1'b0;
                @(negedge clk);
            end
            chk($sformatf("bit%0d_held", i), 16'(ok), 16'd1);
        end
        chk("done_pulse", 16'(mon_done), 16'd1);
        chk("end_idle txd/en/busy/ready", 16'({mon_txd, mon_en, mon_busy, mon_ready}), 16'b1001);
    endtask

    task automatic send_a(input logic [7:0] data, input logic [15:0] frame, input bit spurious);
        tx_data_a  = data;
        exp_a      = frame;
        tx_valid_a = 1'b1;
        inj_a      = spurious;
        @(negedge clk);
        tx_valid_a = 1'b0;
        inj_a      = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [15:0] frame;
        bit          spurious;
    } vec_t;

    vec_t vecs[3];
    logic seen;

    initial begin
        vecs[0] = '{8'hA5, 16'b1_1010_0101_0, 1'b0};
        vecs[1] = '{8'h3C, 16'b1_0011_1100_0, 1'b0};
        vecs[2] = '{8'h81, 16'b1_1000_0001_0, 1'b1};

        // Reset: two cycles high
        @(negedge clk);
        chk("ready_in_reset_a", 16'(tx_ready_a), 16'd0);
        @(negedge clk);
        chk("ready_in_reset_b", 16'(tx_ready_b), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_a txd/en/busy/done/ready", 16'({txd_a, baud_en_a, busy_a, done_a, tx_ready_a}), 16'b10001);
        chk("reset_b txd/en/busy/done/ready", 16'({txd_b, baud_en_b, busy_b, done_b, tx_ready_b}), 16'b10001);

        // Spurious ticks in IDLE change nothing
        for (int k = 0; k < 2; k++) begin
            inj_a = 1'b1;
            @(negedge clk);
            inj_a = 1'b0;
            chk("spurious_idle", 16'({txd_a, baud_en_a, busy_a, done_a, tx_ready_a}), 16'b10001);
            @(negedge clk);
        end

        // Table-driven single frames
        sel = 1'b0;
        for (int v = 0; v < 3; v++) begin
            send_a(vecs[v].data, vecs[v].frame, vecs[v].spurious);
            check_frame(10, PA);
            @(negedge clk);
            chk($sformatf("done_once_v%0d", v), 16'(done_a), 16'd0);
        end

        // Back-to-back with tx_valid held high
        tx_data_a  = 8'h00;
        exp_a      = 16'b1_0000_0000_0;
        tx_valid_a = 1'b1;
        @(negedge clk);
        tx_data_a = 8'hFF;
        exp_a     = 16'b1_1111_1111_0;
        check_frame(10, PA);
        @(negedge clk);
        chk("b2b_en_gap en/txd/busy", 16'({baud_en_a, txd_a, busy_a}), 16'b101);
        tx_valid_a = 1'b0;
        check_frame(10, PA);
        @(negedge clk);

        // Reset in the middle of data bit 3
        send_a(8'h3C, 16'b1_0011_1100_0, 1'b0);
        repeat (4 * PA + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort txd/en/busy/done/ready", 16'({txd_a, baud_en_a, busy_a, done_a, tx_ready_a}), 16'b10000);
        if (q_a.size() > 0) void'(q_a.pop_front());
        rst  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done_a !== 1'b0 || busy_a !== 1'b0) seen = 1'b1;
        end
        chk("no_done_after_abort", 16'(seen), 16'd0);
        chk("ready_after_abort", 16'(tx_ready_a), 16'd1);
        send_a(8'hA5, 16'b1_1010_0101_0, 1'b0);
        check_frame(10, PA);

        // 7 data bits, 2 stop bits, P=8: 80-cycle frame
        sel        = 1'b1;
        tx_data_b  = 7'h55;
        exp_b      = 16'b11_101_0101_0;
        tx_valid_b = 1'b1;
        @(negedge clk);
        tx_valid_b = 1'b0;
        check_frame(10, PB);
        @(negedge clk);
        chk("done_once_b", 16'(done_b), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
UART transmit controller that sequences the shared baud-rate counter.
- Accepts a parallel byte over a valid/ready handshake.
- Enables the baud counter for the duration of one frame.
- Uses each counter pulse to advance through the start, data and stop bits on txd.
- Sits between the bus-side TX register and the serial pin. The baud counter instance stays external; this block only drives its enable and consumes its pulse.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clk  input  1  system clock (100 MHz); all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
tx_data  input  DATA_BITS  byte to send; sampled only on the accept edge.
tx_valid  input  1  requester has a byte.
tx_ready  output  1  sequencer can accept a byte.
baud_en  output  1  drives the baud counter en input.
baud_tick  input  1  baud counter out; one-cycle pulse per bit period while enabled.
txd  output  1  serial line; idle high.
busy  output  1  frame in progress.
tx_done  output  1  one-cycle pulse at frame completion.

Behaviour:
Baud counter contract:
- Counter is held cleared while baud_en=0.
- While baud_en=1 it pulses baud_tick for 1 cycle every P cycles, first pulse P cycles after baud_en rises.
- baud_tick is ignored whenever state=IDLE.

Reset (rst=1 at a rising edge):
- State goes to IDLE; txd=1, baud_en=0, busy=0, tx_done=0.
- Bit and stop counters are cleared; the shift register is cleared.
- tx_ready=0 while rst is high, 1 in IDLE thereafter.
- Reset mid-frame aborts immediately: txd returns high the next cycle and no tx_done is produced.

State machine (all outputs registered except tx_ready = (state==IDLE) & ~rst):
- IDLE:
  - txd=1, baud_en=0, busy=0.
  - On tx_valid & tx_ready: load tx_data into the shift register and go to START.
  - tx_data is not sampled at any other time.
- START:
  - txd=0, baud_en=1, busy=1.
  - On baud_tick: go to DATA, bit_idx=0, txd=shift[0].
- DATA:
  - txd=current LSB of the shift register.
  - On baud_tick with bit_idx < DATA_BITS-1: shift right, bit_idx+1.
  - On baud_tick with bit_idx = DATA_BITS-1: go to STOP, txd=1, stop_idx=0.
- STOP:
  - txd=1.
  - On baud_tick with stop_idx < STOP_BITS-1: stop_idx+1.
  - Otherwise: go to IDLE, baud_en=0, busy=0, tx_done=1 for exactly one cycle.

Timing:
- txd falls on the cycle after the accept edge.
- Frame length: (1+DATA_BITS+STOP_BITS)*P cycles from the txd falling edge to the IDLE transition.
- Back-to-back frames:
  - tx_ready is high in the first IDLE cycle, so an immediate accept is allowed.
  - baud_en is low for at least 1 cycle between frames, so the counter phase restarts with every frame.
- tx_valid held high during a frame has no effect until IDLE. The requester must hold tx_data stable only on the accept edge.

Widths:
- bit_idx is sized as clog2(DATA_BITS).
- stop_idx is 1 bit.
- No counter wraps past its terminal value.

Boundary cases:
- baud_tick asserted in the same cycle as the accept is ignored (still IDLE).
- A spurious baud_tick while baud_en=0 is ignored.

Test Plan:
- Reset: rst high 2 cycles, baud counter P=4 → txd=1, baud_en=0, busy=0, tx_ready=1 after reset drops, no tx_done.
- Single frame, tx_data=8'hA5, P=4 → txd sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; tx_done pulses once, 40 cycles after txd falls.
- Back-to-back: 8'h00 then 8'hFF with tx_valid held high → second accept in the first IDLE cycle; baud_en low exactly 1 cycle; second frame 0,1×8,1.
- STOP_BITS=2, DATA_BITS=7, data 7'h55, P=8 → frame 80 cycles; stop high 16 cycles; tx_done once.
- Reset mid-frame at DATA bit 3 → next cycle txd=1, busy=0, baud_en=0, no tx_done; new byte accepted normally afterwards.
- Spurious baud_tick pulses in IDLE and on the accept cycle → no state change; the frame still starts with a full P-cycle start bit.
